recon_io_master: RTL and testbench
==================================

Name: recon_io_master

Overview:
- Avalon-MM master (initiator) that drives the RECON IO peripheral's 6-bit-address register bus from a simple command/response stream.
- Also autonomously services the peripheral's level irq:
  - reads IRQ_STATUS;
  - clears it write-1-to-clear with the value read;
  - emits the captured status on a backpressured event stream.
- Sits between a host-side controller (CPU-less sequencer, UART bridge) and one IO peripheral instance.

Parameters:
- ADDR_WIDTH, 6, Avalon address width.
- READ_LATENCY, 1, fixed slave read latency in cycles, 1..4; readdata sampled exactly this many edges after the read bus-accept edge.
- IRQ_STATUS_ADDR, 7, word address of the W1C interrupt status register.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready at clk edge
- cmd_write  in  1  1=write, 0=read
- cmd_address  in  ADDR_WIDTH  target register
- cmd_writedata  in  32  write data
- rsp_valid  out  1  one-cycle completion pulse, no backpressure
- rsp_write  out  1  completed op was a write
- rsp_readdata  out  32  read data (0 for writes)
- evt_valid  out  1  IRQ event pending
- evt_ready  in  1  event consumed when evt_valid&&evt_ready
- evt_status  out  32  IRQ_STATUS value that was cleared
- irq_svc_en  in  1  enables autonomous IRQ service
- irq  in  1  peripheral interrupt, level
- avm_address  out  ADDR_WIDTH  bus address
- avm_chipselect  out  1  bus select
- avm_read  out  1  read strobe
- avm_write  out  1  write strobe
- avm_writedata  out  32  bus write data
- avm_readdata  in  32  bus read data
- avm_waitrequest  in  1  slave stall; tie 0 for IO peripheral

Behaviour:
- Reset (async, reset_n=0):
  - FSM->IDLE.
  - All outputs 0: cmd_ready, rsp_*, evt_*, avm_*.
  - In-flight transaction and pending event are dropped.
- FSM states: IDLE, CMD_BUS, CMD_RWAIT, CMD_RSP, IRQ_RD, IRQ_RWAIT, IRQ_CLR, (event held in register, not a state).
- IDLE arbitration, evaluated every cycle:
  - If irq && irq_svc_en && !evt_valid: go to IRQ_RD; cmd_ready=0 this cycle. IRQ has priority.
  - Else cmd_ready=1 (combinational). On handshake, latch write/address/data and go to CMD_BUS.
- Bus phase (CMD_BUS, IRQ_RD, IRQ_CLR):
  - Registered avm_chipselect=1 plus avm_read or avm_write.
  - Address and writedata stable until the edge where avm_waitrequest=0 (bus-accept edge).
  - Strobes deassert the cycle after acceptance; at most one outstanding transaction.
- Read data:
  - avm_readdata sampled at the READ_LATENCY-th edge after the read bus-accept edge (CMD_RWAIT/IRQ_RWAIT down-counter).
  - Writes skip the wait.
- Command completion (CMD_RSP):
  - rsp_valid=1 for exactly one cycle; rsp_write reflects the op.
  - rsp_readdata is updated only by reads (0 on writes) and holds until the next response.
  - Then back to IDLE.
- Minimum command turnaround with waitrequest=0 and READ_LATENCY=1:
  - write: accept edge E0, bus cycle, rsp_valid in cycle after E0+1 (3 cycles/cmd).
  - read: one extra cycle.
- IRQ service:
  - IRQ_RD reads IRQ_STATUS_ADDR; IRQ_RWAIT captures the value.
  - Captured value 0 (spurious/already cleared): return to IDLE, no write, no event.
  - Captured value nonzero: IRQ_CLR writes the same value to IRQ_STATUS_ADDR. On write accept, load evt_status, set evt_valid=1, go to IDLE.
  - evt_valid/evt_status hold until evt_ready. evt_valid clears at the handshake edge.
  - No new IRQ service while evt_valid=1; commands are still served.
  - No rsp_valid for IRQ-service transactions.
- irq_svc_en deasserted mid-service: the current sequence completes; no new service starts.
- Events latched in the peripheral between our read and clear are not cleared (W1C of read value only) and re-raise irq.
- avm_waitrequest held high: FSM stalls indefinitely in the bus state; no timeout.

Test Plan:
- Write 0x0000_00FF to addr 0 with waitrequest=0 -> avm_write one cycle, address 0, data 0xFF; rsp_valid one cycle later, rsp_write=1, rsp_readdata=0.
- Read addr 2 with slave returning 0x0000_A5A5 at latency 1 -> rsp_valid one cycle, rsp_write=0, rsp_readdata=0xA5A5; same for READ_LATENCY=3 with correct sample edge.
- waitrequest high 4 cycles during write to addr 3 -> avm_address/writedata/avm_write stable all 5 cycles; single rsp_valid after release.
- irq=1, irq_svc_en=1, IRQ_STATUS reads 0x0000_0005 -> read addr 7, then write 0x5 to addr 7; evt_valid=1, evt_status=0x5 held while evt_ready=0; clears on handshake.
- irq and cmd_valid asserted same cycle in IDLE -> IRQ sequence first, cmd_ready=0 until it finishes, then command executes. Second irq while evt_valid=1 -> ignored until event consumed.
- Status read returns 0 -> no write, no event. reset_n pulsed low mid-read -> all outputs 0 immediately, FSM IDLE, no rsp_valid.

Source files
------------

// File: rtl/recon_io_master.sv
// Avalon-MM master for the RECON IO register bus: serves host commands and
// autonomously reads/clears the peripheral IRQ status, reporting it as an event.
module recon_io_master #(
  parameter int ADDR_WIDTH      = 6,
  parameter int READ_LATENCY    = 1,
  parameter int IRQ_STATUS_ADDR = 7
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_address,
  input  logic [31:0]           cmd_writedata,
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic [31:0]           rsp_readdata,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [31:0]           evt_status,
  input  logic                  irq_svc_en,
  input  logic                  irq,
  output logic [ADDR_WIDTH-1:0] avm_address,
  output logic                  avm_chipselect,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [31:0]           avm_writedata,
  input  logic [31:0]           avm_readdata,
  input  logic                  avm_waitrequest
);

  typedef enum logic [2:0] {
    IDLE, CMD_BUS, CMD_RWAIT, CMD_RSP, IRQ_RD, IRQ_RWAIT, IRQ_CLR
  } state_t;

  localparam logic [1:0]            LAT_LOAD = 2'(READ_LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] IRQ_ADDR = ADDR_WIDTH'(IRQ_STATUS_ADDR);

  state_t     state;
  logic [1:0] lat_cnt;
  logic       irq_start;
  logic       bus_accept;

  // A held event blocks new service so the status of one service is never overwritten.
  assign irq_start  = irq && irq_svc_en && !evt_valid;
  assign cmd_ready  = reset_n && (state == IDLE) && !irq_start;
  assign bus_accept = !avm_waitrequest;

  // Sequencer: arbitration, bus strobes, read-latency wait, response and event registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      lat_cnt        <= 2'd0;
      rsp_valid      <= 1'b0;
      rsp_write      <= 1'b0;
      rsp_readdata   <= 32'd0;
      evt_valid      <= 1'b0;
      evt_status     <= 32'd0;
      avm_address    <= '0;
      avm_chipselect <= 1'b0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= 32'd0;
    end else begin
      if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (irq_start) begin
            state          <= IRQ_RD;
            avm_chipselect <= 1'b1;
            avm_read       <= 1'b1;
            avm_write      <= 1'b0;
            avm_address    <= IRQ_ADDR;
          end else if (cmd_valid && cmd_ready) begin
            state          <= CMD_BUS;
            avm_chipselect <= 1'b1;
            avm_read       <= !cmd_write;
            avm_write      <= cmd_write;
            avm_address    <= cmd_address;
            avm_writedata  <= cmd_writedata;
          end
        end
        CMD_BUS: begin
          if (bus_accept) begin
            avm_chipselect <= 1'b0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            lat_cnt        <= LAT_LOAD;
            if (avm_write) begin
              rsp_valid    <= 1'b1;
              rsp_write    <= 1'b1;
              rsp_readdata <= 32'd0;
              state        <= CMD_RSP;
            end else begin
              state        <= CMD_RWAIT;
            end
          end
        end
        CMD_RWAIT: begin
          if (lat_cnt == 2'd0) begin
            rsp_valid    <= 1'b1;
            rsp_write    <= 1'b0;
            rsp_readdata <= avm_readdata;
            state        <= CMD_RSP;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        CMD_RSP: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        IRQ_RD: begin
          if (bus_accept) begin
            avm_chipselect <= 1'b0;
            avm_read       <= 1'b0;
            lat_cnt        <= LAT_LOAD;
            state          <= IRQ_RWAIT;
          end
        end
        IRQ_RWAIT: begin
          if (lat_cnt == 2'd0) begin
            // Zero status means a spurious or already-cleared interrupt: nothing to clear.
            if (avm_readdata == 32'd0) begin
              state <= IDLE;
            end else begin
              avm_chipselect <= 1'b1;
              avm_write      <= 1'b1;
              avm_writedata  <= avm_readdata;
              state          <= IRQ_CLR;
            end
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        IRQ_CLR: begin
          if (bus_accept) begin
            avm_chipselect <= 1'b0;
            avm_write      <= 1'b0;
            evt_valid      <= 1'b1;
            evt_status     <= avm_writedata;
            state          <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_recon_io_master.sv
// Bench for recon_io_master: latency-1 instance with a full slave model and
// a latency-3 instance for the read-sample edge.
module tb_recon_io_master;

  typedef struct packed {logic w; logic [31:0] d;} rsp_t;
  typedef struct packed {logic w; logic [5:0] a; logic [31:0] d;} bus_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid, cmd_valid3, cmd_write, evt_ready, irq_svc_en, irq, irq3;
  logic [5:0]  cmd_address;
  logic [31:0] cmd_writedata;
  logic        avm_waitrequest, wait3;
  logic [31:0] slave_data, irq_status;

  logic        cmd_ready, rsp_valid, rsp_write, evt_valid;
  logic [31:0] rsp_readdata, evt_status, avm_writedata, avm_readdata;
  logic [5:0]  avm_address;
  logic        avm_chipselect, avm_read, avm_write;

  logic        cmd_ready3, rsp_valid3, rsp_write3, evt_valid3;
  logic [31:0] rsp_readdata3, evt_status3, avm_writedata3, avm_readdata3;
  logic [5:0]  avm_address3;
  logic        avm_chipselect3, avm_read3, avm_write3;

  int n_cmp = 0;
  int n_bad = 0;
  rsp_t exp_rsp[$];
  bus_t bus_log[$];

  always #5 clk = ~clk;

  recon_io_master #(.ADDR_WIDTH(6), .READ_LATENCY(1), .IRQ_STATUS_ADDR(7)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_readdata(rsp_readdata),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_status(evt_status),
    .irq_svc_en(irq_svc_en), .irq(irq),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_read(avm_read),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest));

  recon_io_master #(.ADDR_WIDTH(6), .READ_LATENCY(3), .IRQ_STATUS_ADDR(7)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
    .rsp_valid(rsp_valid3), .rsp_write(rsp_write3), .rsp_readdata(rsp_readdata3),
    .evt_valid(evt_valid3), .evt_ready(evt_ready), .evt_status(evt_status3),
    .irq_svc_en(irq_svc_en), .irq(irq3),
    .avm_address(avm_address3), .avm_chipselect(avm_chipselect3), .avm_read(avm_read3),
    .avm_write(avm_write3), .avm_writedata(avm_writedata3), .avm_readdata(avm_readdata3),
    .avm_waitrequest(wait3));

  // Slave model: readdata is valid only in the cycle before the correct sample edge.
  logic [3:0]  pipe1 = 4'd0;
  logic [3:0]  pipe3 = 4'd0;
  logic [31:0] val1 = 32'd0;
  logic [31:0] val3 = 32'd0;
  logic        acc_rd1, acc_rd3;
  assign acc_rd1 = avm_chipselect && avm_read && !avm_waitrequest;
  assign acc_rd3 = avm_chipselect3 && avm_read3 && !wait3;
  assign avm_readdata  = pipe1[0] ? val1 : 32'hDEAD_BEEF;
  assign avm_readdata3 = pipe3[2] ? val3 : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    pipe1 <= {pipe1[2:0], acc_rd1};
    pipe3 <= {pipe3[2:0], acc_rd3};
    if (acc_rd1) val1 <= (avm_address == 6'd7) ? irq_status : slave_data;
    if (acc_rd3) val3 <= slave_data;
  end

  // Log every accepted transfer of the latency-1 instance.
  always @(posedge clk) begin
    if (reset_n && avm_chipselect && !avm_waitrequest && (avm_read || avm_write))
      bus_log.push_back({avm_write, avm_address, avm_write ? avm_writedata : 32'd0});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic send_cmd(input int sel, input logic w, input logic [5:0] a,
                          input logic [31:0] d, output int waited);
    cmd_write = w; cmd_address = a; cmd_writedata = d;
    if (sel == 0) cmd_valid = 1'b1; else cmd_valid3 = 1'b1;
    waited = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if ((sel == 0) ? cmd_ready : cmd_ready3) begin
        waited = i;
        break;
      end
    end
    if (waited >= 0) @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_valid3 = 1'b0;
  endtask

  task automatic wait_rsp(input int sel, output int n, output logic w, output logic [31:0] d);
    n = -1; w = 1'b0; d = 32'd0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if ((sel == 0) ? rsp_valid : rsp_valid3) begin
        n = i;
        w = (sel == 0) ? rsp_write : rsp_write3;
        d = (sel == 0) ? rsp_readdata : rsp_readdata3;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({cmd_ready, rsp_valid, rsp_write, evt_valid, avm_chipselect, avm_read, avm_write} !== 7'd0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b required 0000000",
        {cmd_ready, rsp_valid, rsp_write, evt_valid, avm_chipselect, avm_read, avm_write});
    end
    n_cmp++;
    if ({rsp_readdata, evt_status, avm_writedata, avm_address} !== 102'd0) begin
      n_bad++; $display("FAIL reset_data: rsp_readdata=%h evt_status=%h wd=%h addr=%h required 0",
        rsp_readdata, evt_status, avm_writedata, avm_address);
    end
    @(posedge clk); #1; reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL idle_ready: got %b required 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    int waited, n; logic w; logic [31:0] d; rsp_t e;
    @(posedge clk); #1;
    bus_log.delete();
    exp_rsp.push_back({1'b1, 32'd0});
    send_cmd(0, 1'b1, 6'd0, 32'h0000_00FF, waited);
    wait_rsp(0, n, w, d);
    n_cmp++;
    if (n !== 2) begin n_bad++; $display("FAIL wr_latency: got %0d required 2", n); end
    e = exp_rsp.pop_front();
    n_cmp++;
    if (w !== e.w || d !== e.d) begin
      n_bad++; $display("FAIL wr_rsp: got w=%b d=%h required w=%b d=%h", w, d, e.w, e.d);
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL wr_pulse: rsp_valid=%b required 0", rsp_valid); end
    n_cmp++;
    if (bus_log.size() != 1) begin
      n_bad++; $display("FAIL wr_bus_count: got %0d required 1", bus_log.size());
    end else if (bus_log[0] !== {1'b1, 6'd0, 32'h0000_00FF}) begin
      n_bad++; $display("FAIL wr_bus: got %h required %h", bus_log[0], {1'b1, 6'd0, 32'h0000_00FF});
    end
  endtask

  task automatic test_read(input int sel, input logic [31:0] val, input int lat_exp);
    int waited, n; logic w; logic [31:0] d; rsp_t e;
    @(posedge clk); #1;
    slave_data = val;
    exp_rsp.push_back({1'b0, val});
    send_cmd(sel, 1'b0, 6'd2, 32'h1111_2222, waited);
    wait_rsp(sel, n, w, d);
    n_cmp++;
    if (n !== lat_exp) begin n_bad++; $display("FAIL rd_latency%0d: got %0d required %0d", sel, n, lat_exp); end
    e = exp_rsp.pop_front();
    n_cmp++;
    if (w !== e.w || d !== e.d) begin
      n_bad++; $display("FAIL rd_rsp%0d: got w=%b d=%h required w=%b d=%h", sel, w, d, e.w, e.d);
    end
    @(negedge clk);
    n_cmp++;
    if (((sel == 0) ? rsp_valid : rsp_valid3) !== 1'b0 ||
        ((sel == 0) ? rsp_readdata : rsp_readdata3) !== val) begin
      n_bad++; $display("FAIL rd_hold%0d: readdata=%h required %h with rsp_valid 0",
        sel, (sel == 0) ? rsp_readdata : rsp_readdata3, val);
    end
  endtask

  task automatic test_waitrequest();
    int waited, n; logic w; logic [31:0] d; rsp_t e;
    @(posedge clk); #1;
    bus_log.delete();
    avm_waitrequest = 1'b1;
    exp_rsp.push_back({1'b1, 32'd0});
    send_cmd(0, 1'b1, 6'd3, 32'h1234_5678, waited);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({avm_chipselect, avm_write, avm_read, avm_address, avm_writedata, rsp_valid} !==
          {1'b1, 1'b1, 1'b0, 6'd3, 32'h1234_5678, 1'b0}) begin
        n_bad++; $display("FAIL stall_hold c%0d: cs=%b wr=%b addr=%h wd=%h rsp=%b required 1 1 03 12345678 0",
          i, avm_chipselect, avm_write, avm_address, avm_writedata, rsp_valid);
      end
      if (i == 4) begin @(posedge clk); #1; avm_waitrequest = 1'b0; end
    end
    wait_rsp(0, n, w, d);
    e = exp_rsp.pop_front();
    n_cmp++;
    if (n !== 1 || w !== e.w || d !== e.d) begin
      n_bad++; $display("FAIL stall_rsp: got n=%0d w=%b d=%h required n=1 w=%b d=%h", n, w, d, e.w, e.d);
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0 || bus_log.size() != 1) begin
      n_bad++; $display("FAIL stall_single: rsp_valid=%b transfers=%0d required 0 and 1", rsp_valid, bus_log.size());
    end
  endtask

  task automatic test_irq();
    int got; logic saw_rsp;
    @(posedge clk); #1;
    bus_log.delete();
    irq_status = 32'h0000_0005;
    irq = 1'b1;
    got = 0; saw_rsp = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
      if (evt_valid) begin got = 1; break; end
    end
    irq = 1'b0;
    n_cmp++;
    if (got != 1 || evt_status !== 32'h0000_0005) begin
      n_bad++; $display("FAIL irq_evt: evt_valid_seen=%0d status=%h required 1 and 00000005", got, evt_status);
    end
    n_cmp++;
    if (saw_rsp !== 1'b0) begin n_bad++; $display("FAIL irq_no_rsp: rsp_valid seen=%b required 0", saw_rsp); end
    n_cmp++;
    if (bus_log.size() != 2) begin
      n_bad++; $display("FAIL irq_bus_count: got %0d required 2", bus_log.size());
    end else if (bus_log[0] !== {1'b0, 6'd7, 32'd0} || bus_log[1] !== {1'b1, 6'd7, 32'h5}) begin
      n_bad++; $display("FAIL irq_bus: got %h,%h required read 7 then write 5 to 7", bus_log[0], bus_log[1]);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (evt_valid !== 1'b1 || evt_status !== 32'h5) begin
        n_bad++; $display("FAIL evt_hold c%0d: valid=%b status=%h required 1 00000005", i, evt_valid, evt_status);
      end
    end
    @(posedge clk); #1; evt_ready = 1'b1;
    @(posedge clk); #1; evt_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL evt_clear: got %b required 0", evt_valid); end
  endtask

  task automatic test_priority();
    int waited, n, got; logic w; logic [31:0] d; rsp_t e;
    @(posedge clk); #1;
    bus_log.delete();
    irq_status = 32'h0000_0003;
    exp_rsp.push_back({1'b1, 32'd0});
    irq = 1'b1;
    send_cmd(0, 1'b1, 6'd1, 32'h0000_0011, waited);
    n_cmp++;
    if (waited < 1) begin n_bad++; $display("FAIL prio_ready: cmd waited %0d cycles required >=1", waited); end
    wait_rsp(0, n, w, d);
    e = exp_rsp.pop_front();
    n_cmp++;
    if (n !== 2 || w !== e.w || d !== e.d) begin
      n_bad++; $display("FAIL prio_rsp: got n=%0d w=%b d=%h required n=2 w=%b d=%h", n, w, d, e.w, e.d);
    end
    n_cmp++;
    if (bus_log.size() != 3) begin
      n_bad++; $display("FAIL prio_bus_count: got %0d required 3", bus_log.size());
    end else if (bus_log[0] !== {1'b0, 6'd7, 32'd0} || bus_log[1] !== {1'b1, 6'd7, 32'h3} ||
                 bus_log[2] !== {1'b1, 6'd1, 32'h11}) begin
      n_bad++; $display("FAIL prio_order: got %h,%h,%h required irq read, irq clear, command",
        bus_log[0], bus_log[1], bus_log[2]);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (bus_log.size() != 3 || evt_valid !== 1'b1 || evt_status !== 32'h3) begin
      n_bad++; $display("FAIL prio_block: transfers=%0d evt_valid=%b status=%h required 3 1 00000003",
        bus_log.size(), evt_valid, evt_status);
    end
    irq_status = 32'd0;
    @(posedge clk); #1; evt_ready = 1'b1;
    @(posedge clk); #1; evt_ready = 1'b0;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_log.size() > 3) begin got = 1; break; end
    end
    irq = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (got != 1 || bus_log.size() != 4) begin
      n_bad++; $display("FAIL zero_status_count: seen=%0d transfers=%0d required 1 and 4", got, bus_log.size());
    end else if (bus_log[3] !== {1'b0, 6'd7, 32'd0} || evt_valid !== 1'b0) begin
      n_bad++; $display("FAIL zero_status: got %h evt_valid=%b required read of 7 and no event",
        bus_log[3], evt_valid);
    end
  endtask

  task automatic test_reset_mid_read();
    int waited; logic seen;
    @(posedge clk); #1;
    bus_log.delete();
    avm_waitrequest = 1'b1;
    send_cmd(0, 1'b0, 6'd4, 32'd0, waited);
    @(negedge clk);
    n_cmp++;
    if (avm_read !== 1'b1 || avm_address !== 6'd4) begin
      n_bad++; $display("FAIL mid_pre: read=%b addr=%h required 1 04", avm_read, avm_address);
    end
    #1 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({cmd_ready, rsp_valid, evt_valid, avm_chipselect, avm_read, avm_write, avm_address} !== 12'd0) begin
      n_bad++; $display("FAIL mid_reset: got %b required all 0",
        {cmd_ready, rsp_valid, evt_valid, avm_chipselect, avm_read, avm_write, avm_address});
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    avm_waitrequest = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid || avm_read || !cmd_ready) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0 || bus_log.size() != 0) begin
      n_bad++; $display("FAIL mid_after: activity=%b transfers=%0d required 0 0", seen, bus_log.size());
    end
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_valid3 = 1'b0; cmd_write = 1'b0;
    cmd_address = 6'd0; cmd_writedata = 32'd0;
    evt_ready = 1'b0; irq_svc_en = 1'b1; irq = 1'b0; irq3 = 1'b0;
    avm_waitrequest = 1'b0; wait3 = 1'b0;
    slave_data = 32'd0; irq_status = 32'd0;
    test_reset();
    test_write();
    test_read(0, 32'h0000_A5A5, 3);
    test_read(1, 32'h1357_9BDF, 5);
    test_waitrequest();
    test_irq();
    test_priority();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
